// File: rtl/alu_pipe_pkg.sv
// ============================================================================
// Module   : alu_pipe_pkg
// Brief    : Opcode, flag and FSM state types shared by the ALU pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pipe_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_XOR = 4'd2,
        ALU_NOT = 4'd3,
        ALU_SHL = 4'd4,
        ALU_SHR = 4'd5,
        ALU_ADD = 4'd6,
        ALU_ADC = 4'd7,
        ALU_SUB = 4'd8,
        ALU_SBB = 4'd9,
        ALU_INC = 4'd10,
        ALU_DEC = 4'd11,
        ALU_MUL = 4'd12
    } enum_alu_opcode_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } struct_alu_flag_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_pipe_state_t;

    localparam logic c_MODE_LOGIC = 1'b0;
    localparam logic c_MODE_ARITH = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module   : alu_pipe_if
// Brief    : Operation request / result handshake bundle for alu_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
    parameter int DATA_WIDTH = 16
);
    import alu_pipe_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_a;
    logic [DATA_WIDTH-1:0]  in_b;
    enum_alu_opcode_t       alu_opcode;
    logic                   alu_mode;
    logic                   input_carry;
    logic                   use_ext_carry;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  alu_out;
    struct_alu_flag_t       alu_out_flag;
    logic                   busy;

    modport master (
        output in_valid, in_a, in_b, alu_opcode, alu_mode, input_carry,
               use_ext_carry, out_ready,
        input  in_ready, out_valid, alu_out, alu_out_flag, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, alu_opcode, alu_mode, input_carry,
               use_ext_carry, out_ready,
        output in_ready, out_valid, alu_out, alu_out_flag, busy
    );

endinterface

`default_nettype wire

// File: rtl/alu_pipe_mul_iter.sv
// ============================================================================
// Module   : alu_mul_iter
// Brief    : Iterative shift-add multiplier, one multiplier bit per step.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_mul_iter
    import alu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      start,
    input  wire logic                      step,
    input  wire logic [DATA_WIDTH-1:0]     a,
    input  wire logic [DATA_WIDTH-1:0]     b,
    output logic                           done,
    output logic [2*DATA_WIDTH-1:0]        product
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]        r_cnt;
    logic [2*DATA_WIDTH-1:0] w_addend;
    logic [2*DATA_WIDTH-1:0] w_acc_next;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_mcand  <= {{DATA_WIDTH{1'b0}}, a};
            r_acc    <= '0;
            r_mplier <= b;
            r_cnt    <= '0;
        end else if (step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // The final step's sum is handed out combinationally so it loads on that same edge.
    assign done    = step && (r_cnt == c_LAST);
    assign product = w_acc_next;

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Registered valid/ready ALU with held carry and iterative multiply.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MUL_EN     = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_pipe_if.slave   bus
);

    localparam int MSB = DATA_WIDTH - 1;

    alu_pipe_state_t         r_state;
    logic                    r_busy;
    logic                    r_valid;
    logic [MSB:0]            r_out;
    struct_alu_flag_t        r_flag;

    logic                    w_accept;
    logic                    w_is_mul;
    logic                    w_cin;
    logic                    w_mul_done;
    logic [2*DATA_WIDTH-1:0] w_mul_prod;
    logic [MSB:0]            w_res;
    logic [DATA_WIDTH:0]     w_ext;
    logic                    w_carry;
    logic                    w_ovf;
    logic                    w_legal;
    struct_alu_flag_t        w_flag;
    struct_alu_flag_t        w_mul_flag;

    assign bus.in_ready     = (r_state == IDLE) && (!r_valid || bus.out_ready);
    assign bus.out_valid    = r_valid;
    assign bus.alu_out      = r_out;
    assign bus.alu_out_flag = r_flag;
    assign bus.busy         = r_busy;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_is_mul = (MUL_EN != 0) && (bus.alu_mode == c_MODE_ARITH)
                      && (bus.alu_opcode == ALU_MUL);
    // The held C flag is the carry of whatever result last loaded.
    assign w_cin    = bus.use_ext_carry ? bus.input_carry : r_flag.carry;

    always_comb begin
        w_res   = '0;
        w_ext   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_legal = 1'b1;
        if (bus.alu_mode == c_MODE_LOGIC) begin
            case (bus.alu_opcode)
                ALU_AND: begin w_res = bus.in_a & bus.in_b; w_carry = r_flag.carry; end
                ALU_OR:  begin w_res = bus.in_a | bus.in_b; w_carry = r_flag.carry; end
                ALU_XOR: begin w_res = bus.in_a ^ bus.in_b; w_carry = r_flag.carry; end
                ALU_NOT: begin w_res = ~bus.in_a;           w_carry = r_flag.carry; end
                ALU_SHL: begin w_res = {bus.in_a[MSB-1:0], 1'b0}; w_carry = bus.in_a[MSB]; end
                ALU_SHR: begin w_res = {1'b0, bus.in_a[MSB:1]};   w_carry = bus.in_a[0];   end
                default: w_legal = 1'b0;
            endcase
        end else begin
            case (bus.alu_opcode)
                ALU_ADD, ALU_ADC: begin
                    w_ext = {1'b0, bus.in_a} + {1'b0, bus.in_b}
                          + (DATA_WIDTH+1)'((bus.alu_opcode == ALU_ADC) ? w_cin : 1'b0);
                    w_ovf = (bus.in_a[MSB] == bus.in_b[MSB]) && (w_ext[MSB] != bus.in_a[MSB]);
                end
                ALU_SUB, ALU_SBB: begin
                    w_ext = {1'b0, bus.in_a} - {1'b0, bus.in_b}
                          - (DATA_WIDTH+1)'((bus.alu_opcode == ALU_SBB) ? w_cin : 1'b0);
                    w_ovf = (bus.in_a[MSB] != bus.in_b[MSB]) && (w_ext[MSB] != bus.in_a[MSB]);
                end
                ALU_INC: begin
                    w_ext = {1'b0, bus.in_a} + (DATA_WIDTH+1)'(1);
                    w_ovf = !bus.in_a[MSB] && w_ext[MSB];
                end
                ALU_DEC: begin
                    w_ext = {1'b0, bus.in_a} - (DATA_WIDTH+1)'(1);
                    w_ovf = bus.in_a[MSB] && !w_ext[MSB];
                end
                default: w_legal = 1'b0;
            endcase
            if (w_legal) begin
                w_res   = w_ext[MSB:0];
                w_carry = w_ext[DATA_WIDTH];
            end
        end
        w_flag = '0;
        if (w_legal) begin
            w_flag.carry    = w_carry;
            w_flag.zero     = (w_res == '0);
            w_flag.negative = w_res[MSB];
            w_flag.overflow = w_ovf;
        end
    end

    always_comb begin
        w_mul_flag          = '0;
        w_mul_flag.carry    = |w_mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        w_mul_flag.zero     = (w_mul_prod[MSB:0] == '0);
        w_mul_flag.negative = w_mul_prod[MSB];
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_iter #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (w_accept && w_is_mul),
                .step    (r_state == MUL),
                .a       (bus.in_a),
                .b       (bus.in_b),
                .done    (w_mul_done),
                .product (w_mul_prod)
            );
        end else begin : g_no_mul
            assign w_mul_done = 1'b0;
            assign w_mul_prod = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_out   <= '0;
            r_flag  <= '0;
        end else begin
            if (r_valid && bus.out_ready) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= MUL;
                            r_busy  <= 1'b1;
                        end else begin
                            r_out   <= w_res;
                            r_flag  <= w_flag;
                            r_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_out   <= w_mul_prod[MSB:0];
                        r_flag  <= w_mul_flag;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
